spell_mem_dff: RTL and testbench
================================

Name: spell_mem_dff

Overview:
Flip-flop based memory for the spell CPU core, with two independent byte-wide address spaces: code and data.
- Accessed through a select/write/data_ready handshake, one operation per select assertion.
- Sits between the core's memory interface and the rest of the design; stands in for an SRAM macro in small builds.

Parameters:
CODE_DEPTH, 32, number of code bytes; power of two, 2..256.
DATA_DEPTH, 32, number of data bytes; power of two, 2..256.

Ports:
clock  input  1  system clock; all state updates on its rising edge.
reset  input  1  synchronous, active-low reset.
select  input  1  access request; held high until data_ready seen, then dropped.
addr  input  8  byte address, sampled with select.
data_in  input  8  write data, sampled with select.
memory_type_data  input  1  address-space select: 1 = data space, 0 = code space.
write  input  1  1 = write, 0 = read; sampled with select.
data_out  output  8  registered read data.
data_ready  output  1  access complete; high while the completed request is still selected.

Behaviour:
- Storage: code_mem[CODE_DEPTH] and data_mem[DATA_DEPTH], 8 bits each.
- Index = addr modulo depth (low log2(depth) bits); higher addr bits are ignored, so addresses wrap.
- Reset (reset==0 at a rising edge):
  - every byte of both memories cleared to 0;
  - data_out=0, data_ready=0, state=IDLE.
  - Reset overrides any access in progress; the interrupted access is lost.
- State IDLE, select==1 at a rising edge:
  - write==1: selected memory[index] <= data_in; data_out unchanged.
  - write==0: data_out <= selected memory[index].
  - data_ready <= 1; go to DONE.
  - Latency: one clock, so data_ready and data_out are valid one cycle after select is first sampled high.
- State DONE:
  - No further memory access, even if addr, data_in, write or memory_type_data change.
  - data_ready stays 1 while select==1.
  - When select==0 at an edge: data_ready <= 0, return to IDLE.
  - A new request needs select low for at least one edge.
- IDLE with select==0: no change; data_out holds its last read value indefinitely.
- Address spaces are fully independent: a write to code[5] never affects data[5], and the reverse.
- Read of a never-written location returns 0.
- Read-after-write to the same location in the next transaction returns the new value.
- Inputs are assumed stable while select is high and data_ready is low.

Optional Feature:
Macro SPELL_MEM_DFF_CODE_WRITE_PROTECT_EN.
- Defined: write requests to the code space (memory_type_data==0, write==1) leave code_mem unchanged, but the handshake completes normally with data_ready after one cycle. Data-space writes are unaffected.
- Undefined (default): code space is writable exactly like data space.
- The test plan below assumes the macro is undefined.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release -> data_out=0, data_ready=0; reads of code[5] and data[5] return 0.
- Data write then cross-space read: write 42 to data[5] (select until data_ready, then drop) -> read code[5] gives data_out=0; read data[5] gives 42; read data[6] gives 0.
- Code write isolation: write 99 to code[5] -> read code[5] gives 99; read data[5] still gives 42.
- Handshake timing: assert select for a read -> data_ready rises exactly one clock later and stays high while select is held. Change addr while in DONE -> data_out does not change. Drop select -> data_ready goes low on the next edge.
- Address wrap: with DATA_DEPTH=32, write 7 to data[3], then read data addr 35 -> returns 7.
- Reset mid-operation: write 42 to data[5], then assert reset=0 while select=1 -> data_ready=0, and a subsequent read of data[5] returns 0.

Source files
------------

// File: rtl/spell_mem_dff.sv
// Flip-flop code/data byte memory behind a select/write/data_ready handshake; SPELL_MEM_DFF_CODE_WRITE_PROTECT_EN makes code space read-only.
// One-cycle access latency; data_ready is held while select stays high, and the next request is taken only after select has dropped.
module spell_mem_dff #(
    parameter int CODE_DEPTH = 32,
    parameter int DATA_DEPTH = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       select,
    input  logic [7:0] addr,
    input  logic [7:0] data_in,
    input  logic       memory_type_data,
    input  logic       write,
    output logic [7:0] data_out,
    output logic       data_ready
);

    localparam int CODE_AW = (CODE_DEPTH > 1) ? $clog2(CODE_DEPTH) : 1;
    localparam int DATA_AW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;

`ifdef SPELL_MEM_DFF_CODE_WRITE_PROTECT_EN
    localparam bit CODE_WR_EN = 1'b0;
`else
    localparam bit CODE_WR_EN = 1'b1;
`endif

    typedef enum logic {
        IDLE,
        DONE
    } state_t;

    state_t              state;
    logic [7:0]          code_mem [CODE_DEPTH];
    logic [7:0]          data_mem [DATA_DEPTH];
    logic [CODE_AW-1:0]  code_idx;
    logic [DATA_AW-1:0]  data_idx;
    logic [7:0]          rd_dat;
    logic                addr_unused;

    // Upper address bits are dropped so accesses wrap within each space.
    assign code_idx    = addr[CODE_AW-1:0];
    assign data_idx    = addr[DATA_AW-1:0];
    assign addr_unused = ^addr;
    assign rd_dat      = memory_type_data ? data_mem[data_idx] : code_mem[code_idx];

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < CODE_DEPTH; i++) code_mem[i] <= '0;
            for (int i = 0; i < DATA_DEPTH; i++) data_mem[i] <= '0;
            state      <= IDLE;
            data_out   <= '0;
            data_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (select) begin
                        if (write) begin
                            if (memory_type_data)
                                data_mem[data_idx] <= data_in;
                            else if (CODE_WR_EN)
                                code_mem[code_idx] <= data_in;
                        end else begin
                            data_out <= rd_dat;
                        end
                        data_ready <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    // Only the falling select re-arms the port; input changes here are ignored.
                    if (!select) begin
                        data_ready <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    data_ready <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spell_mem_dff.sv
// Directed self-checking bench for spell_mem_dff with hand-computed expected values.
module tb_spell_mem_dff;

    logic       clock = 1'b0;
    logic       reset;
    logic       select;
    logic [7:0] addr;
    logic [7:0] data_in;
    logic       memory_type_data;
    logic       write;
    logic [7:0] data_out;
    logic       data_ready;

    int total  = 0;
    int passed = 0;

    spell_mem_dff #(
        .CODE_DEPTH(32),
        .DATA_DEPTH(32)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .select           (select),
        .addr             (addr),
        .data_in          (data_in),
        .memory_type_data (memory_type_data),
        .write            (write),
        .data_out         (data_out),
        .data_ready       (data_ready)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // One complete transaction: select until ready, then drop select.
    task automatic access(input string tag, input logic mt, input logic wr,
                          input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] exp_out);
        memory_type_data = mt;
        write            = wr;
        addr             = a;
        data_in          = d;
        select           = 1'b1;
        tick();
        check({tag, "_rdy"}, {7'd0, data_ready}, 8'd1);
        check({tag, "_out"}, data_out, exp_out);
        select = 1'b0;
        tick();
        check({tag, "_drop"}, {7'd0, data_ready}, 8'd0);
    endtask

    initial begin
        reset            = 1'b0;
        select           = 1'b0;
        addr             = 8'd0;
        data_in          = 8'd0;
        memory_type_data = 1'b0;
        write            = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rst_out", data_out, 8'd0);
        check("rst_rdy", {7'd0, data_ready}, 8'd0);

        access("rd_code5_init", 1'b0, 1'b0, 8'd5, 8'd0, 8'd0);
        access("rd_data5_init", 1'b1, 1'b0, 8'd5, 8'd0, 8'd0);

        // Data write, then cross-space reads.
        access("wr_data5",      1'b1, 1'b1, 8'd5, 8'd42, 8'd0);
        access("rd_code5_x",    1'b0, 1'b0, 8'd5, 8'd0,  8'd0);
        access("rd_data5",      1'b1, 1'b0, 8'd5, 8'd0,  8'd42);
        access("rd_data6",      1'b1, 1'b0, 8'd6, 8'd0,  8'd0);

        // Code write isolation.
        access("wr_code5",      1'b0, 1'b1, 8'd5, 8'd99, 8'd0);
        access("rd_code5",      1'b0, 1'b0, 8'd5, 8'd0,  8'd99);
        access("rd_data5_iso",  1'b1, 1'b0, 8'd5, 8'd0,  8'd42);

        // Handshake timing with inputs changing while in DONE.
        memory_type_data = 1'b1;
        write            = 1'b0;
        addr             = 8'd6;
        select           = 1'b1;
        #1;
        check("hs_pre_rdy", {7'd0, data_ready}, 8'd0);
        tick();
        check("hs_rdy1", {7'd0, data_ready}, 8'd1);
        check("hs_out1", data_out, 8'd0);
        addr = 8'd5;
        tick();
        check("hs_rdy2", {7'd0, data_ready}, 8'd1);
        check("hs_out2", data_out, 8'd0);
        memory_type_data = 1'b0;
        tick();
        check("hs_rdy3", {7'd0, data_ready}, 8'd1);
        check("hs_out3", data_out, 8'd0);
        select = 1'b0;
        tick();
        check("hs_drop", {7'd0, data_ready}, 8'd0);
        check("hs_hold1", data_out, 8'd0);
        tick();
        tick();
        check("hs_hold2", data_out, 8'd0);
        check("hs_idle_rdy", {7'd0, data_ready}, 8'd0);

        // Address wrap in both spaces.
        access("wr_data3",      1'b1, 1'b1, 8'd3,  8'd7, 8'd0);
        access("rd_data35",     1'b1, 1'b0, 8'd35, 8'd0, 8'd7);
        access("rd_code37",     1'b0, 1'b0, 8'd37, 8'd0, 8'd99);
        access("rd_data229",    1'b1, 1'b0, 8'd229, 8'd0, 8'd42);

        // Reset in the middle of an access.
        access("wr_data5_b",    1'b1, 1'b1, 8'd5, 8'd42, 8'd42);
        memory_type_data = 1'b1;
        write            = 1'b1;
        addr             = 8'd5;
        data_in          = 8'd77;
        select           = 1'b1;
        reset            = 1'b0;
        tick();
        check("mid_rst_rdy", {7'd0, data_ready}, 8'd0);
        check("mid_rst_out", data_out, 8'd0);
        reset  = 1'b1;
        select = 1'b0;
        tick();
        check("mid_rst_idle", {7'd0, data_ready}, 8'd0);
        access("rd_data5_post", 1'b1, 1'b0, 8'd5, 8'd0, 8'd0);
        access("rd_code5_post", 1'b0, 1'b0, 8'd5, 8'd0, 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
